// File: rtl/mips_pkg.sv
// Shared types for the fetch-stage next-PC logic.
// Holds the reset PC, the sequencer state and the next-PC select codes.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_t;

    // j/jal keeps the top nibble of the delay-slot PC
    function automatic logic [31:0] j_target(
        input logic [31:0] pc,
        input logic [25:0] idx
    );
        return {pc[31:28], idx, 2'b00};
    endfunction

endpackage

// File: rtl/npc_adder.sv
// Combinational pc+4 / pc+8 adder for the fetch stage.
// Both sums wrap modulo 2^32.
module npc_adder (
    input  logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc_plus8
);

    assign pc_plus4 = pc + 32'd4;
    assign pc_plus8 = pc + 32'd8;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register, next-PC select, run/halt FSM and fetch counter.
// Optional PC_ALIGN_CHK_EN: misaligned next-PC halts fetch and sets misalign.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_take,
    input  logic [31:0]      br_target,
    input  logic             j_take,
    input  logic [25:0]      j_index,
    input  logic             jr_take,
    input  logic [31:0]      jr_target,
    input  logic             halt,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus8,
    output logic             fetch_valid,
    output logic [CNT_W-1:0] fetch_count,
    output logic             misalign
);

    state_t           state, state_n;
    npc_sel_t         sel;
    logic [31:0]      pc_n;
    logic [31:0]      pc_plus4;
    logic [31:0]      npc;
    logic [CNT_W-1:0] cnt_n;

    npc_adder u_add (
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .pc_plus8 (pc_plus8)
    );

    // several takes may be high at once; highest priority wins
    always_comb begin
        sel = NPC_SEQ;
        priority case (1'b1)
            jr_take: sel = NPC_JR;
            j_take:  sel = NPC_J;
            br_take: sel = NPC_BR;
            default: sel = NPC_SEQ;
        endcase
    end

    always_comb begin
        npc = pc_plus4;
        unique case (sel)
            NPC_JR:  npc = jr_target;
            NPC_J:   npc = j_target(pc, j_index);
            NPC_BR:  npc = br_target;
            NPC_SEQ: npc = pc_plus4;
        endcase
    end

`ifdef PC_ALIGN_CHK_EN
    logic mis_q, mis_n;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = fetch_count;
        mis_n   = mis_q;
        unique case (state)
            BOOT: state_n = RUN;
            RUN: begin
                if (!stall) begin
                    if (npc[1:0] != 2'b00) begin
                        mis_n   = 1'b1;
                        state_n = HALT;
                    end else begin
                        pc_n  = npc;
                        cnt_n = fetch_count + CNT_W'(1);
                        if (halt) state_n = HALT;
                    end
                end
            end
            HALT: state_n = HALT;
            default: state_n = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) mis_q <= 1'b0;
        else       mis_q <= mis_n;
    end

    assign misalign = mis_q;
`else
    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = fetch_count;
        unique case (state)
            BOOT: state_n = RUN;
            RUN: begin
                if (!stall) begin
                    pc_n  = npc;
                    cnt_n = fetch_count + CNT_W'(1);
                    if (halt) state_n = HALT;
                end
            end
            HALT: state_n = HALT;
            default: state_n = HALT;
        endcase
    end

    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            fetch_count <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            fetch_count <= cnt_n;
        end
    end

    assign fetch_valid = (state == RUN);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_take;
    logic [31:0] br_target;
    logic        j_take;
    logic [25:0] j_index;
    logic        jr_take;
    logic [31:0] jr_target;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic        fetch_valid;
    logic [31:0] fetch_count;
    logic        misalign;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] p8;
        logic        valid;
        logic [31:0] cnt;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_take     (br_take),
        .br_target   (br_target),
        .j_take      (j_take),
        .j_index     (j_index),
        .jr_take     (jr_take),
        .jr_target   (jr_target),
        .halt        (halt),
        .pc          (pc),
        .pc_plus8    (pc_plus8),
        .fetch_valid (fetch_valid),
        .fetch_count (fetch_count),
        .misalign    (misalign)
    );

    task automatic chk32(string n, string f, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s.%s got=%h want=%h", n, f, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk32(e.name, "pc", pc, e.pc);
            chk32(e.name, "pc_plus8", pc_plus8, e.p8);
            chk32(e.name, "valid", {31'd0, fetch_valid}, {31'd0, e.valid});
            chk32(e.name, "count", fetch_count, e.cnt);
            chk32(e.name, "misalign", {31'd0, misalign}, {31'd0, e.mis});
        end
    end

    task automatic idle_in();
        reset = 0; stall = 0; halt = 0;
        br_take = 0; j_take = 0; jr_take = 0;
        br_target = '0; j_index = '0; jr_target = '0;
    endtask

    // apply current inputs for one edge, then queue the expected post-edge view
    task automatic cyc(string n, logic [31:0] epc, logic ev,
                       logic [31:0] ecnt, logic emis, logic [31:0] ep8);
        exp_t e;
        @(posedge clk);
        #1;
        e.name = n; e.pc = epc; e.p8 = ep8;
        e.valid = ev; e.cnt = ecnt; e.mis = emis;
        q.push_back(e);
        idle_in();
    endtask

    task automatic step(string n, logic [31:0] epc, logic ev,
                        logic [31:0] ecnt);
        cyc(n, epc, ev, ecnt, 1'b0, epc + 32'd8);
    endtask

    initial begin
        idle_in();
        reset = 1;
        step("reset", 32'h3000, 0, 0);
        step("boot", 32'h3000, 1, 0);
        step("seq1", 32'h3004, 1, 1);
        step("seq2", 32'h3008, 1, 2);
        step("seq3", 32'h300C, 1, 3);
        step("seq4", 32'h3010, 1, 4);

        for (int i = 0; i < 3; i++) begin
            stall = 1; br_take = 1; br_target = 32'h3100;
            halt = (i == 1);
            step("stall", 32'h3010, 1, 4);
        end
        step("unstall", 32'h3014, 1, 5);

        jr_take = 1; jr_target = 32'h3020;
        step("jr3020", 32'h3020, 1, 6);
        jr_take = 1; j_take = 1; br_take = 1;
        jr_target = 32'h4000; j_index = 26'h0000C10; br_target = 32'h5000;
        step("prio", 32'h4000, 1, 7);
        j_take = 1; j_index = 26'h0000C10;
        step("j", 32'h3040, 1, 8);

        jr_take = 1; jr_target = 32'hFFFF_FFFC;
        cyc("top", 32'hFFFF_FFFC, 1, 9, 0, 32'h0000_0004);
        step("wrap", 32'h0000_0000, 1, 10);

        jr_take = 1; jr_target = 32'h3008;
        step("jr3008", 32'h3008, 1, 11);
        halt = 1; j_take = 1; j_index = 26'h0000C40;
        step("halt_j", 32'h3100, 0, 12);
        br_take = 1; br_target = 32'h3200;
        step("halted_br", 32'h3100, 0, 12);
        step("halted_idle", 32'h3100, 0, 12);

        reset = 1; jr_take = 1; jr_target = 32'h7000;
        step("reset2", 32'h3000, 0, 0);
        step("boot2", 32'h3000, 1, 0);
        jr_take = 1; jr_target = 32'h3002;
`ifdef PC_ALIGN_CHK_EN
        cyc("misalign", 32'h3000, 0, 0, 1, 32'h3008);
        cyc("mis_hold", 32'h3000, 0, 0, 1, 32'h3008);
`else
        step("noalign", 32'h3002, 1, 1);
        step("noalign2", 32'h3006, 1, 2);
`endif

        for (int t = 0; t < 20 && q.size() > 0; t++) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
